multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle 32-bit datapath.
- Sits directly upstream of the ALU control decoder:
  - drives the 2-bit ALUOp consumed there (00 add, 01 sub, 10 funct-decoded, 11 xor);
  - drives every other datapath strobe.
- Sequences fetch/decode/execute/memory/writeback per instruction, with a memory-ready handshake and an instruction-retired counter.

Parameters:
- CNT_W, 32, width of instr_count.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word opcode.
- OP_SW, 6'b101011, store word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_J, 6'b000010, jump opcode.
- OP_ADDI, 6'b001000, add-immediate opcode.
- OP_XORI, 6'b001110, xor-immediate opcode.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- ALUOp  output  2  to ALU control.
- ALUSrcA  output  1  0=PC, 1=register A.
- ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  PC write if ALU zero.
- IorD  output  1  0=PC address, 1=ALUOut address.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  1=MDR to register file.
- RegDst  output  1  1=rd, 0=rt.
- RegWrite  output  1  register file write.
- state  output  4  current state, for debug.
- illegal  output  1  sticky: an unsupported opcode was decoded.
- instr_count  output  CNT_W  instructions retired.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12-15 go to FETCH on the next edge.
- Reset (rst high, asynchronous):
  - state=FETCH, illegal=0, instr_count=0.
  - While rst is high, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond and RegWrite are forced 0.
  - Reset mid-instruction abandons the instruction with no count.
- Outputs not listed for a state are 0. Outputs are a combinational function of state, plus opcode in IEXEC, plus mem_ready in FETCH.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready.
  - Holds while !mem_ready; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI/XORI->IEXEC.
  - Any other opcode -> FETCH with illegal set to 1 (sticky until reset); not counted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1; holds until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; holds until mem_ready, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp=11 if opcode==OP_XORI, else 00 -> IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- instr_count:
  - Increments by 1 on the edge leaving MEMWB, MEMWR (with mem_ready), RWB, BRANCH, JUMP or IWB.
  - Wraps from all-ones to 0.
- Cycle counts with mem_ready constantly 1: lw=5, sw=4, R-type=4, addi/xori=4, beq=3, j=3.
- Each wait cycle with mem_ready=0 adds one cycle in FETCH/MEMRD/MEMWR.
- mem_ready is ignored in all other states.
- opcode must be stable from DECODE to instruction end; it is only sampled in DECODE/MEMADR/IEXEC.

Test Plan:
- Reset then mem_ready=1, opcode=000000 -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in RWB; instr_count=1.
- opcode=100011, mem_ready held 0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles, MemRead=IorD=1 throughout; MEMWB has MemtoReg=1; total 8 cycles; count increments once.
- opcode=001110 then 001000 -> ALUOp=11 in the first IEXEC, 00 in the second; instr_count=2 after both.
- opcode=000100 -> BRANCH has ALUOp=01, PCWriteCond=1, PCSource=01; PCWrite=0; 3 cycles.
- opcode=111111 -> DECODE->FETCH, illegal=1 and stays 1 through a following lw; instr_count unchanged by the illegal opcode.
- Assert rst asynchronously mid-MEMWR -> state=0 immediately, MemWrite=0, instr_count=0, illegal=0; counter forced to all-ones via a long run wraps to 0 on the next retire.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle 32-bit datapath.
// Moore-style sequencer: every datapath strobe comes from the current state.
// The only exceptions are ALUOp in IEXEC, which depends on opcode, and
// IRWrite/PCWrite in FETCH, which depend on mem_ready.
// Also keeps a sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_control #(
  parameter int CNT_W = 32,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_XORI  = 6'b001110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   decode_bad;
  logic   retire;

  logic mem_read_c;
  logic mem_write_c;
  logic ir_write_c;
  logic pc_write_c;
  logic pc_write_cond_c;
  logic reg_write_c;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state sequencing plus the illegal-decode and retire conditions.
  always_comb begin
    state_d    = FETCH;
    decode_bad = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)          state_d = MEMADR;
        else if (opcode == OP_RTYPE)                     state_d = EXEC;
        else if (opcode == OP_BEQ)                       state_d = BRANCH;
        else if (opcode == OP_J)                         state_d = JUMP;
        else if (opcode == OP_ADDI || opcode == OP_XORI) state_d = IEXEC;
        else begin
          state_d    = FETCH;
          decode_bad = 1'b1;
        end
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  begin state_d = FETCH; retire = 1'b1; end
      MEMWR:  begin
        state_d = mem_ready ? FETCH : MEMWR;
        retire  = mem_ready;
      end
      EXEC:   state_d = RWB;
      RWB:    begin state_d = FETCH; retire = 1'b1; end
      BRANCH: begin state_d = FETCH; retire = 1'b1; end
      JUMP:   begin state_d = FETCH; retire = 1'b1; end
      IEXEC:  state_d = IWB;
      IWB:    begin state_d = FETCH; retire = 1'b1; end
      default: state_d = FETCH;
    endcase
  end

  // Datapath control decode for the current state (Moore outputs).
  always_comb begin
    ALUOp           = 2'b00;
    ALUSrcA         = 1'b0;
    ALUSrcB         = 2'b00;
    PCSource        = 2'b00;
    IorD            = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    reg_write_c     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        ALUSrcB    = 2'b01;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mem_read_c = 1'b1;
        IorD       = 1'b1;
      end
      MEMWB: begin
        reg_write_c = 1'b1;
        MemtoReg    = 1'b1;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        IorD        = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        reg_write_c = 1'b1;
        RegDst      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA         = 1'b1;
        ALUOp           = 2'b01;
        pc_write_cond_c = 1'b1;
        PCSource        = 2'b01;
      end
      JUMP: begin
        pc_write_c = 1'b1;
        PCSource   = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_XORI) ? 2'b11 : 2'b00;
      end
      IWB: reg_write_c = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are held off for as long as reset is asserted.
  assign MemRead     = mem_read_c      & ~rst;
  assign MemWrite    = mem_write_c     & ~rst;
  assign IRWrite     = ir_write_c      & ~rst;
  assign PCWrite     = pc_write_c      & ~rst;
  assign PCWriteCond = pc_write_cond_c & ~rst;
  assign RegWrite    = reg_write_c     & ~rst;
  assign state       = state_q;

  // Sticky flag: set on any unsupported opcode seen in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             illegal <= 1'b0;
    else if (decode_bad) illegal <= 1'b1;
  end

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_count <= '0;
    else if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// A small counter width is used so the wrap-around is reached in a short run.
// Expected behaviour comes from a per-instruction model: the state sequence
// each opcode should walk through, and the control word each state should drive.
module tb_multicycle_control;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [5:0]          opcode;
  logic                mem_ready;
  logic [1:0]          ALUOp;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          PCSource;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic                RegDst;
  logic                RegWrite;
  logic [3:0]          state;
  logic                illegal;
  logic [TB_CNT_W-1:0] instr_count;

  int compared = 0;
  int mismatched = 0;

  logic [TB_CNT_W-1:0] exp_count;
  logic                exp_illegal;

  multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Packed control word:
  // {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
  //  MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite}.
  function automatic logic [15:0] observed();
    return {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
            MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite};
  endfunction

  // Control word each state should drive, written straight from the state table.
  function automatic logic [15:0] expected_word(int st, logic [5:0] op, logic mr);
    logic [1:0] aop, srcb, pcs;
    logic srca, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw;
    {aop, srcb, pcs} = '0;
    {srca, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw} = '0;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; aop = (op == 6'b001110) ? 2'b11 : 2'b00; end
      11: rw = 1;
      default: ;
    endcase
    return {aop, srca, srcb, pcs, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw};
  endfunction

  // One comparison point: count it and report any difference.
  task automatic checkOutput(string tag, logic [15:0] obs, logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one instruction: build the expected state walk from the opcode and
  // the number of wait cycles, drive mem_ready accordingly and check every
  // cycle. A non-negative abort_at asserts reset mid-cycle at that step.
  task automatic applyStimulus(logic [5:0] op, int fetch_wait, int mem_wait, int abort_at);
    int seq[$];
    int wait_idx;
    bit legal;
    legal = 1;
    for (int i = 0; i <= fetch_wait; i++) seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'b100011: begin
        seq.push_back(2);
        for (int i = 0; i <= mem_wait; i++) seq.push_back(3);
        seq.push_back(4);
      end
      6'b101011: begin
        seq.push_back(2);
        for (int i = 0; i <= mem_wait; i++) seq.push_back(5);
      end
      6'b000000: begin seq.push_back(6); seq.push_back(7); end
      6'b000100: seq.push_back(8);
      6'b000010: seq.push_back(9);
      6'b001000, 6'b001110: begin seq.push_back(10); seq.push_back(11); end
      default: legal = 0;
    endcase

    opcode   = op;
    wait_idx = 0;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0 && seq[k] != seq[k-1]) wait_idx = 0;
      if (seq[k] == 0)                      mem_ready = (wait_idx == fetch_wait);
      else if (seq[k] == 3 || seq[k] == 5)  mem_ready = (wait_idx == mem_wait);
      else                                  mem_ready = 1'($urandom_range(0, 1));
      wait_idx++;
      @(negedge clk);
      checkOutput($sformatf("state op=%b step=%0d", op, k), {12'd0, state}, {12'd0, 4'(seq[k])});
      checkOutput($sformatf("ctrl op=%b step=%0d", op, k), observed(),
                  expected_word(seq[k], op, mem_ready));
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1;
        exp_count   = '0;
        exp_illegal = 1'b0;
        checkOutput("abort state", {12'd0, state}, 16'd0);
        checkOutput("abort strobes",
                    {10'd0, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite}, 16'd0);
        checkOutput("abort count", {12'd0, instr_count}, {12'd0, exp_count});
        checkOutput("abort illegal", {15'd0, illegal}, {15'd0, exp_illegal});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (legal) exp_count = exp_count + 1'b1;
    else       exp_illegal = 1'b1;
    checkOutput($sformatf("count op=%b", op), {12'd0, instr_count}, {12'd0, exp_count});
    checkOutput($sformatf("illegal op=%b", op), {15'd0, illegal}, {15'd0, exp_illegal});
  endtask

  logic [5:0] op_pool [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000010, 6'b001000, 6'b001110, 6'b010101};

  initial begin
    rst         = 1'b1;
    opcode      = 6'b000000;
    mem_ready   = 1'b1;
    exp_count   = '0;
    exp_illegal = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset state", {12'd0, state}, 16'd0);
    checkOutput("reset strobes",
                {10'd0, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite}, 16'd0);
    checkOutput("reset count", {12'd0, instr_count}, 16'd0);
    checkOutput("reset illegal", {15'd0, illegal}, 16'd0);
    rst = 1'b0;

    // Directed sequence.
    applyStimulus(6'b000000, 0, 0, -1);
    applyStimulus(6'b100011, 0, 3, -1);
    applyStimulus(6'b001110, 0, 0, -1);
    applyStimulus(6'b001000, 0, 0, -1);
    applyStimulus(6'b000100, 1, 0, -1);
    applyStimulus(6'b000010, 0, 0, -1);
    applyStimulus(6'b111111, 0, 0, -1);
    applyStimulus(6'b100011, 2, 1, -1);
    applyStimulus(6'b101011, 0, 3, 4);

    // Randomized instruction mix; the small counter wraps several times.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(op_pool[$urandom_range(0, 7)], int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
